// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register behind the 32x32 register file: drives read addresses,
// bypasses same-cycle WB writes, snoops WB while stalled, and counts inserted bubbles.
module id_ex_operand_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [4:0]        ra1,
  output logic [4:0]        ra2,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_wa,
  input  logic [31:0]       wb_data,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [31:0] op1;
  logic [31:0] op2;
  logic        snoop_en;
  logic        bubble;

  assign ra1 = id_rs1;
  assign ra2 = id_rs2;

  // The file writes on the edge, so a same-cycle WB write is not yet visible on rd1/rd2.
  always_comb begin
    op1 = rd1;
    if (id_rs1 == 5'd0)
      op1 = '0;
    else if (wb_reg_write && (wb_wa == id_rs1))
      op1 = wb_data;
  end

  always_comb begin
    op2 = rd2;
    if (id_rs2 == 5'd0)
      op2 = '0;
    else if (wb_reg_write && (wb_wa == id_rs2))
      op2 = wb_data;
  end

  assign snoop_en = ex_valid && wb_reg_write && (wb_wa != 5'd0);
  assign bubble   = flush || (!stall && !id_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (stall) begin
      if (snoop_en && (wb_wa == ex_rs1))
        ex_op1 <= wb_data;
      if (snoop_en && (wb_wa == ex_rs2))
        ex_op2 <= wb_data;
    end else begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_imm   <= id_imm;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
      ex_op1   <= op1;
      ex_op2   <= op2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt <= '0;
    else if (bubble && !(&bubble_cnt))
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

endmodule
